// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage interlock/forwarding controller:
// register index width and EX operand forwarding-select encodings.
package id_hazard_ctrl_pkg;

    localparam int RFIDX_WIDTH = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/id_hazard_ctrl_tag.sv
// One registered stage of the shadow tag pipeline. Only the valid bit is
// cleared by reset; the payload is meaningless while valid is low.
module hz_tag_slot #(
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_d,
    input  logic [RFIDX_WIDTH-1:0] rd_d,
    input  logic                   reg_write_d,
    input  logic                   is_load_d,
    input  logic [RFIDX_WIDTH-1:0] rs1_d,
    input  logic [RFIDX_WIDTH-1:0] rs2_d,
    output logic                   valid_q,
    output logic [RFIDX_WIDTH-1:0] rd_q,
    output logic                   reg_write_q,
    output logic                   is_load_q,
    output logic [RFIDX_WIDTH-1:0] rs1_q,
    output logic [RFIDX_WIDTH-1:0] rs2_q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_q        <= rd_d;
        reg_write_q <= reg_write_d;
        is_load_q   <= is_load_d;
        rs1_q       <= rs1_d;
        rs2_q       <= rs2_d;
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage interlock controller: load-use/jalr stalls, branch flush
// bubbles and EX forwarding selects from an EX/MEM/WB shadow tag pipeline.
module id_hazard_ctrl #(
    parameter int RFIDX_WIDTH = id_hazard_ctrl_pkg::RFIDX_WIDTH,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [RFIDX_WIDTH-1:0] id_rs1_index,
    input  logic [RFIDX_WIDTH-1:0] id_rs2_index,
    input  logic [RFIDX_WIDTH-1:0] id_rd_index,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   id_jalr,
    input  logic                   bxx_flush,
    output logic                   stall_if,
    output logic                   bubble_ex,
    output logic                   flush_if_id,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    import id_hazard_ctrl_pkg::*;

    logic                   ex_valid_d;
    logic                   ex_valid_q,  mem_valid_q,  wb_valid_q;
    logic [RFIDX_WIDTH-1:0] ex_rd_q,     mem_rd_q,     wb_rd_q;
    logic                   ex_rw_q,     mem_rw_q,     wb_rw_q;
    logic                   ex_ld_q,     mem_ld_q,     wb_ld_q;
    logic [RFIDX_WIDTH-1:0] ex_rs1_q,    mem_rs1_q,    wb_rs1_q;
    logic [RFIDX_WIDTH-1:0] ex_rs2_q,    mem_rs2_q,    wb_rs2_q;

    logic                   load_use;
    logic                   jalr_hz;
    logic [CNT_W-1:0]       stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0]       flush_cnt_d, flush_cnt_q;
    logic                   unused_tag_bits;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic slot_match(
        input logic                   v,
        input logic                   rw,
        input logic [RFIDX_WIDTH-1:0] rd,
        input logic [RFIDX_WIDTH-1:0] r
    );
        return v & rw & (rd == r) & (r != '0);
    endfunction

    // A load sitting in MEM has no data yet; the load-use stall ensures it
    // is already in WB by the time a dependent instruction reaches EX.
    function automatic logic [1:0] fwd_pick(
        input logic                   ex_v,
        input logic [RFIDX_WIDTH-1:0] r,
        input logic                   mem_v,
        input logic                   mem_rw,
        input logic                   mem_ld,
        input logic [RFIDX_WIDTH-1:0] mem_rd,
        input logic                   wb_v,
        input logic                   wb_rw,
        input logic [RFIDX_WIDTH-1:0] wb_rd
    );
        if (!ex_v) begin
            return FWD_RF;
        end else if (slot_match(mem_v, mem_rw, mem_rd, r) && !mem_ld) begin
            return FWD_MEM;
        end else if (slot_match(wb_v, wb_rw, wb_rd, r)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    // ---- hazard detection (decode vs. registered tags) ----
    always_comb begin
        load_use = ex_valid_q & ex_ld_q &
                   ((id_use_rs1 & slot_match(ex_valid_q, ex_rw_q, ex_rd_q, id_rs1_index)) |
                    (id_use_rs2 & slot_match(ex_valid_q, ex_rw_q, ex_rd_q, id_rs2_index)));
        // jalr reads rs1 in decode with no bypass, so every in-flight writer blocks it.
        jalr_hz  = id_jalr &
                   (slot_match(ex_valid_q,  ex_rw_q,  ex_rd_q,  id_rs1_index) |
                    slot_match(mem_valid_q, mem_rw_q, mem_rd_q, id_rs1_index) |
                    slot_match(wb_valid_q,  wb_rw_q,  wb_rd_q,  id_rs1_index));
        stall_if    = id_valid & (load_use | jalr_hz) & ~bxx_flush;
        bubble_ex   = stall_if | bxx_flush;
        flush_if_id = bxx_flush;
        ex_valid_d  = id_valid & ~bubble_ex;
    end

    // ---- tag pipeline: ID -> EX -> MEM -> WB, never frozen ----
    hz_tag_slot #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_ex (
        .clk(clk), .rst_n(rst_n),
        .valid_d(ex_valid_d), .rd_d(id_rd_index), .reg_write_d(id_reg_write),
        .is_load_d(id_mem_read), .rs1_d(id_rs1_index), .rs2_d(id_rs2_index),
        .valid_q(ex_valid_q), .rd_q(ex_rd_q), .reg_write_q(ex_rw_q),
        .is_load_q(ex_ld_q), .rs1_q(ex_rs1_q), .rs2_q(ex_rs2_q)
    );

    hz_tag_slot #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_mem (
        .clk(clk), .rst_n(rst_n),
        .valid_d(ex_valid_q), .rd_d(ex_rd_q), .reg_write_d(ex_rw_q),
        .is_load_d(ex_ld_q), .rs1_d(ex_rs1_q), .rs2_d(ex_rs2_q),
        .valid_q(mem_valid_q), .rd_q(mem_rd_q), .reg_write_q(mem_rw_q),
        .is_load_q(mem_ld_q), .rs1_q(mem_rs1_q), .rs2_q(mem_rs2_q)
    );

    hz_tag_slot #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_wb (
        .clk(clk), .rst_n(rst_n),
        .valid_d(mem_valid_q), .rd_d(mem_rd_q), .reg_write_d(mem_rw_q),
        .is_load_d(mem_ld_q), .rs1_d(mem_rs1_q), .rs2_d(mem_rs2_q),
        .valid_q(wb_valid_q), .rd_q(wb_rd_q), .reg_write_q(wb_rw_q),
        .is_load_q(wb_ld_q), .rs1_q(wb_rs1_q), .rs2_q(wb_rs2_q)
    );

    assign unused_tag_bits = ^{mem_rs1_q, mem_rs2_q, wb_rs1_q, wb_rs2_q, wb_ld_q};

    // ---- EX operand forwarding ----
    always_comb begin
        fwd_a_sel = fwd_pick(ex_valid_q, ex_rs1_q, mem_valid_q, mem_rw_q, mem_ld_q,
                             mem_rd_q, wb_valid_q, wb_rw_q, wb_rd_q);
        fwd_b_sel = fwd_pick(ex_valid_q, ex_rs2_q, mem_valid_q, mem_rw_q, mem_ld_q,
                             mem_rd_q, wb_valid_q, wb_rw_q, wb_rd_q);
    end

    // ---- performance counters (wrap silently) ----
    always_comb begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_if};
        flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, bxx_flush};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: directed scenarios plus random decode
// traffic checked against a list-of-in-flight-instructions reference model.
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_jalr, bxx_flush;
    logic [4:0]  id_rs1_index, id_rs2_index, id_rd_index;
    logic        stall_if, bubble_ex, flush_if_id;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.RFIDX_WIDTH(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index), .id_rd_index(id_rd_index),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_jalr(id_jalr), .bxx_flush(bxx_flush),
        .stall_if(stall_if), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct { bit v; bit rw; bit ld; int rd; int rs1; int rs2; } ins_t;
    typedef struct { bit rst_n; bit valid; bit u1; bit u2; bit rw; bit ld; bit jl; bit fl;
                     int rd; int rs1; int rs2; } in_t;
    typedef struct { int cyc; bit st; bit bub; bit fl; int fa; int fb;
                     bit [31:0] sc; bit [31:0] fc; } exp_t;

    exp_t      sbq[$];
    ins_t      inflight[3];   // [0]=EX, [1]=MEM, [2]=WB
    bit [31:0] m_sc, m_fc;
    bit        known = 1'b0;
    bit        last_stall = 1'b0;
    int        cyc = 0;
    int        total = 0;
    int        bad = 0;

    function automatic bit hits(ins_t e, int r);
        return e.v && e.rw && (e.rd == r) && (r != 0);
    endfunction

    function automatic int fwd(int r);
        if (!inflight[0].v) return 0;
        if (hits(inflight[1], r) && !inflight[1].ld) return 1;
        if (hits(inflight[2], r)) return 2;
        return 0;
    endfunction

    function automatic in_t mk(int rd, int rs1, int rs2, bit u1, bit u2, bit rw, bit ld, bit jl, bit fl);
        in_t x;
        x.rst_n = 1'b1; x.valid = 1'b1; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
        x.u1 = u1; x.u2 = u2; x.rw = rw; x.ld = ld; x.jl = jl; x.fl = fl;
        return x;
    endfunction

    function automatic in_t idle();
        in_t x;
        x = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        x.valid = 1'b0;
        return x;
    endfunction

    task automatic apply(input in_t x);
        exp_t e;
        ins_t n;
        bit   lu, jz, st;
        @(negedge clk);
        rst_n        = x.rst_n;
        id_valid     = x.valid;
        id_rd_index  = x.rd[4:0];
        id_rs1_index = x.rs1[4:0];
        id_rs2_index = x.rs2[4:0];
        id_use_rs1   = x.u1;
        id_use_rs2   = x.u2;
        id_reg_write = x.rw;
        id_mem_read  = x.ld;
        id_jalr      = x.jl;
        bxx_flush    = x.fl;
        lu = inflight[0].ld && ((x.u1 && hits(inflight[0], x.rs1)) || (x.u2 && hits(inflight[0], x.rs2)));
        jz = x.jl && (hits(inflight[0], x.rs1) || hits(inflight[1], x.rs1) || hits(inflight[2], x.rs1));
        st = x.valid && (lu || jz) && !x.fl;
        e.cyc = cyc; e.st = st; e.bub = st || x.fl; e.fl = x.fl;
        e.fa = fwd(inflight[0].rs1); e.fb = fwd(inflight[0].rs2);
        e.sc = m_sc; e.fc = m_fc;
        #1;
        if (known) sbq.push_back(e);
        last_stall = st;
        if (!x.rst_n) begin
            for (int i = 0; i < 3; i++) inflight[i].v = 1'b0;
            m_sc = 0; m_fc = 0; known = 1'b1;
        end else begin
            n.v = x.valid && !st && !x.fl; n.rw = x.rw; n.ld = x.ld;
            n.rd = x.rd; n.rs1 = x.rs1; n.rs2 = x.rs2;
            inflight[2] = inflight[1];
            inflight[1] = inflight[0];
            inflight[0] = n;
            m_sc = m_sc + (st ? 1 : 0);
            m_fc = m_fc + (x.fl ? 1 : 0);
        end
        cyc++;
    endtask

    // Front end behaviour: a stalled decode instruction is presented again.
    task automatic issue(input in_t x);
        int n = 0;
        do begin
            apply(x);
            n++;
        end while (last_stall && n < 6);
    endtask

    task automatic chk(input string name, input int c, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare after the driver settles.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("stall_if",    e.cyc, 64'(stall_if),    64'(e.st));
                chk("bubble_ex",   e.cyc, 64'(bubble_ex),   64'(e.bub));
                chk("flush_if_id", e.cyc, 64'(flush_if_id), 64'(e.fl));
                chk("fwd_a_sel",   e.cyc, 64'(fwd_a_sel),   64'(e.fa));
                chk("fwd_b_sel",   e.cyc, 64'(fwd_b_sel),   64'(e.fb));
                chk("stall_cnt",   e.cyc, 64'(stall_cnt),   64'(e.sc));
                chk("flush_cnt",   e.cyc, 64'(flush_cnt),   64'(e.fc));
            end
        end
    end

    initial begin
        in_t x;
        rst_n = 1'b0; id_valid = 1'b0; id_rd_index = '0; id_rs1_index = '0; id_rs2_index = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_jalr = 1'b0; bxx_flush = 1'b0;
        for (int i = 0; i < 3; i++) inflight[i] = '{default: 0};
        m_sc = 0; m_fc = 0;

        x = idle(); x.rst_n = 1'b0;
        apply(x); apply(x);
        apply(idle());

        // load-use: lw x5 ; add x6,x5,x1
        issue(mk(5, 1, 0, 1, 0, 1, 1, 0, 0));
        issue(mk(6, 5, 1, 1, 1, 1, 0, 0, 0));
        repeat (3) apply(idle());

        // ALU chain: add x3,x1,x2 ; sub x4,x3,x3
        issue(mk(3, 1, 2, 1, 1, 1, 0, 0, 0));
        issue(mk(4, 3, 3, 1, 1, 1, 0, 0, 0));
        repeat (3) apply(idle());

        // jalr after writer: addi x1 ; jalr x0,0(x1)
        issue(mk(1, 0, 0, 1, 0, 1, 0, 0, 0));
        issue(mk(0, 1, 0, 1, 0, 1, 0, 1, 0));
        repeat (3) apply(idle());

        // x0 writer followed by users of x0
        issue(mk(0, 0, 0, 1, 0, 1, 0, 0, 0));
        issue(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        issue(mk(7, 0, 0, 1, 1, 1, 0, 0, 0));
        issue(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
        repeat (3) apply(idle());

        // flush coincident with load-use
        issue(mk(5, 1, 0, 1, 0, 1, 1, 0, 0));
        apply(mk(6, 5, 5, 1, 1, 1, 0, 0, 1));
        repeat (3) apply(idle());

        // reset in the middle of a jalr stall
        issue(mk(1, 0, 0, 1, 0, 1, 0, 0, 0));
        x = mk(0, 1, 0, 1, 0, 1, 0, 1, 0);
        apply(x); apply(x);
        x.rst_n = 1'b0; apply(x);
        x.rst_n = 1'b1; apply(x);
        repeat (2) apply(idle());

        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            x.rst_n = ($urandom_range(0, 59) != 0);
            x.valid = ($urandom_range(0, 7) != 0);
            x.rd    = $urandom_range(0, 3);
            x.rs1   = $urandom_range(0, 3);
            x.rs2   = $urandom_range(0, 3);
            x.u1    = $urandom_range(0, 3) != 0;
            x.u2    = $urandom_range(0, 1) != 0;
            x.rw    = $urandom_range(0, 3) != 0;
            x.ld    = $urandom_range(0, 2) == 0;
            x.jl    = $urandom_range(0, 5) == 0;
            x.fl    = $urandom_range(0, 7) == 0;
            apply(x);
        end

        repeat (3) @(negedge clk);
        #3;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d required=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
